v_rams_arb2: RTL

//   Two-requester round-robin arbiter wrapping a single-port read-first RAM
//   (2**AW x DW). Shares one RAM port between two agents, e.g. a host write

---
 rtl/v_rams_arb2.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/v_rams_arb2.sv
// Two-requester round-robin arbiter in front of a single-port read-first RAM.
// Bursts by one owner are capped at BURST grants while the other port waits.
module v_rams_arb2 #(
    parameter int AW    = 6,
    parameter int DW    = 16,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] a0,
    input  logic [DW-1:0] di0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] di1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1
);

    localparam int            CW      = $clog2(BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lp, lp_nxt;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] mem [2**AW];

    // Grant decision: combinational so an accepted access reaches the RAM
    // at the very next edge.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        lp_nxt    = lp;

        unique case (state)
            IDLE: begin
                if (req0 && (!req1 || lp)) begin
                    gnt0      = 1'b1;
                    state_nxt = OWN0;
                    cnt_nxt   = CNT_ONE;
                end else if (req1) begin
                    gnt1      = 1'b1;
                    state_nxt = OWN1;
                    cnt_nxt   = CNT_ONE;
                end
            end
            OWN0: begin
                if (req0 && (!req1 || cnt < CNT_MAX)) begin
                    gnt0 = 1'b1;
                    if (cnt < CNT_MAX) cnt_nxt = cnt + CNT_ONE;
                end else if (req1) begin
                    gnt1      = 1'b1;
                    state_nxt = OWN1;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            OWN1: begin
                if (req1 && (!req0 || cnt < CNT_MAX)) begin
                    gnt1 = 1'b1;
                    if (cnt < CNT_MAX) cnt_nxt = cnt + CNT_ONE;
                end else if (req0) begin
                    gnt0      = 1'b1;
                    state_nxt = OWN0;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (gnt0) lp_nxt = 1'b0;
        if (gnt1) lp_nxt = 1'b1;

        // A reset cycle must never touch the RAM.
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            lp    <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lp    <= lp_nxt;
        end
    end

    // RAM port mux: port 0 drives the address when nobody is granted.
    assign ram_we   = (gnt0 & we0) | (gnt1 & we1);
    assign ram_addr = gnt1 ? a1 : a0;
    assign ram_din  = gnt1 ? di1 : di0;

    always_ff @(posedge clk) begin
        // NOTE: the RAM array and its output register are deliberately not
        // reset; a memory with reset cannot map onto block RAM.
        if (gnt0 || gnt1) begin
            ram_dout <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
        end
    end

    assign rdata0 = ram_dout;
    assign rdata1 = ram_dout;

    a_onehot_gnt: assert property (@(posedge clk) !(gnt0 && gnt1));
    a_gnt0_req:   assert property (@(posedge clk) gnt0 |-> req0);
    a_gnt1_req:   assert property (@(posedge clk) gnt1 |-> req1);
    a_rst_nognt:  assert property (@(posedge clk) rst |-> !(gnt0 || gnt1));

endmodule
